prog_sequencer: RTL and testbench

Program sequencer for the single-issue core. It owns the program counter and steps it one instruction per cycle. It resolves taken `bne` branches through a small target lookup table and stalls the core while a load or store waits on data memory. It also implements the `Start`/`Done` handshake with the test harness, and sits between instruction memory (driven by `ProgCtr`) and the control decoder / ALU (which supply `Branch`, `Taken`, `MemRead`, `MemWrite`, `HaltInstr`).

---
 rtl/seq_pkg.sv | 24 ++
 rtl/branch_lut.sv | 26 ++
 rtl/prog_sequencer.sv | 131 +++++++++++++
 tb/tb_prog_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the program sequencer.
// Holds the FSM state enum, default widths and the branch target table
// that the assembler regenerates for each program image.
package seq_pkg;

    localparam int unsigned PC_W_DEF      = 10;
    localparam int unsigned LUT_IDX_W_DEF = 3;
    localparam int unsigned CNT_W_DEF     = 16;
    localparam int unsigned LUT_ENTRIES   = 1 << LUT_IDX_W_DEF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        MEMWAIT = 2'd2,
        DONE    = 2'd3
    } seq_state_t;

    // Branch targets indexed by the instruction's LUT field.
    localparam logic [PC_W_DEF-1:0] BRANCH_LUT [LUT_ENTRIES] = '{
        10'd100, 10'd200, 10'd40,  10'd300,
        10'd500, 10'd7,   10'd640, 10'd1000
    };

endpackage

// File: rtl/branch_lut.sv
// Combinational branch target ROM.
// Ports:
//   lutIdx - table index taken from the branch instruction
//   target - branch destination address
// Indices beyond the table (when LUT_IDX_W is widened) read as address 0.
module branch_lut
    import seq_pkg::*;
#(
    parameter int unsigned PC_W      = PC_W_DEF,
    parameter int unsigned LUT_IDX_W = LUT_IDX_W_DEF
) (
    input  logic [LUT_IDX_W-1:0] lutIdx,
    output logic [PC_W-1:0]      target
);

    // Mux out the matching table entry.
    always_comb begin
        target = '0;
        for (int i = 0; i < int'(LUT_ENTRIES); i++) begin
            if (int'(lutIdx) == i) begin
                target = PC_W'(BRANCH_LUT[i]);
            end
        end
    end

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: owns the PC, steps one instruction per cycle,
// resolves taken branches through branch_lut, stalls on data memory
// and runs the Start/Done handshake with the harness.
// Ports:
//   Clk, Reset             - clock, synchronous active-high reset
//   Start, StartAddr       - launch execution (honoured in IDLE/DONE)
//   Branch, Taken, LutIdx  - branch control from decoder / ALU
//   MemRead, MemWrite      - current instruction is a load / store
//   MemReady               - data memory completes the access this cycle
//   HaltInstr              - current instruction is halt
//   ProgCtr                - registered program counter
//   MemReq, WriteEn, Stall - combinational per-cycle control
//   Done                   - registered, program halted
//   InstrCount             - saturating retired-instruction count
module prog_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned PC_W      = PC_W_DEF,
    parameter int unsigned LUT_IDX_W = LUT_IDX_W_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [PC_W-1:0]      StartAddr,
    input  logic                 Branch,
    input  logic                 Taken,
    input  logic [LUT_IDX_W-1:0] LutIdx,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    input  logic                 MemReady,
    input  logic                 HaltInstr,
    output logic [PC_W-1:0]      ProgCtr,
    output logic                 MemReq,
    output logic                 WriteEn,
    output logic                 Stall,
    output logic                 Done,
    output logic [CNT_W-1:0]     InstrCount
);

    seq_state_t      state;
    logic [PC_W-1:0] branchTarget;
    logic [PC_W-1:0] pcInc;
    logic            memInstr;

    branch_lut #(
        .PC_W      (PC_W),
        .LUT_IDX_W (LUT_IDX_W)
    ) uBranchLut (
        .lutIdx (LutIdx),
        .target (branchTarget)
    );

    assign memInstr = MemRead | MemWrite;
    assign pcInc    = ProgCtr + PC_W'(1);

    // Per-cycle control; halt beats memory, memory beats branch.
    always_comb begin
        MemReq  = 1'b0;
        WriteEn = 1'b0;
        Stall   = 1'b0;
        case (state)
            RUN: begin
                if (!HaltInstr) begin
                    if (memInstr) begin
                        MemReq  = 1'b1;
                        WriteEn = MemReady;
                        Stall   = ~MemReady;
                    end else begin
                        WriteEn = 1'b1;
                    end
                end
            end
            MEMWAIT: begin
                MemReq  = 1'b1;
                WriteEn = MemReady;
                Stall   = ~MemReady;
            end
            default: ;
        endcase
    end

    // State, PC, Done and retired-instruction counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            ProgCtr    <= '0;
            Done       <= 1'b0;
            InstrCount <= '0;
        end else begin
            if (WriteEn && (InstrCount != '1)) begin
                InstrCount <= InstrCount + CNT_W'(1);
            end
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        state      <= RUN;
                        ProgCtr    <= StartAddr;
                        Done       <= 1'b0;
                        InstrCount <= '0;
                    end
                end
                RUN: begin
                    if (HaltInstr) begin
                        state <= DONE;
                        Done  <= 1'b1;
                    end else if (memInstr) begin
                        // Branch alongside a memory flag is ignored.
                        if (MemReady) begin
                            ProgCtr <= pcInc;
                        end else begin
                            state <= MEMWAIT;
                        end
                    end else if (Branch && Taken) begin
                        ProgCtr <= branchTarget;
                    end else begin
                        ProgCtr <= pcInc;
                    end
                end
                MEMWAIT: begin
                    if (MemReady) begin
                        state   <= RUN;
                        ProgCtr <= pcInc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: per-scenario tasks drive one
// stimulus vector per cycle and compare against a scoreboard queue.
module tb_prog_sequencer;

    localparam logic L0 = 1'b0;
    localparam logic L1 = 1'b1;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [9:0]  StartAddr;
    logic        Branch;
    logic        Taken;
    logic [2:0]  LutIdx;
    logic        MemRead;
    logic        MemWrite;
    logic        MemReady;
    logic        HaltInstr;
    logic [9:0]  ProgCtr;
    logic        MemReq;
    logic        WriteEn;
    logic        Stall;
    logic        Done;
    logic [15:0] InstrCount;

    logic [9:0]  pcSat;
    logic        mrSat, weSat, stSat, dnSat;
    logic [3:0]  cntSat;

    prog_sequencer #(.PC_W(10), .LUT_IDX_W(3), .CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .Branch(Branch), .Taken(Taken), .LutIdx(LutIdx),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemReady(MemReady),
        .HaltInstr(HaltInstr), .ProgCtr(ProgCtr), .MemReq(MemReq),
        .WriteEn(WriteEn), .Stall(Stall), .Done(Done), .InstrCount(InstrCount)
    );

    // Narrow-counter copy sharing the same stimulus, for saturation.
    prog_sequencer #(.PC_W(10), .LUT_IDX_W(3), .CNT_W(4)) dutSat (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .Branch(Branch), .Taken(Taken), .LutIdx(LutIdx),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemReady(MemReady),
        .HaltInstr(HaltInstr), .ProgCtr(pcSat), .MemReq(mrSat),
        .WriteEn(weSat), .Stall(stSat), .Done(dnSat), .InstrCount(cntSat)
    );

    typedef struct packed {
        logic       rst;
        logic       start;
        logic [9:0] addr;
        logic       br;
        logic       tk;
        logic [2:0] idx;
        logic       rd;
        logic       wr;
        logic       rdy;
        logic       halt;
    } stim_t;

    typedef struct packed {
        logic [9:0]  pc;
        logic        we;
        logic        st;
        logic        mr;
        logic        dn;
        logic [15:0] cnt;
    } obs_t;

    typedef struct packed {
        stim_t s;
        obs_t  e;
    } step_t;

    int   errors = 0;
    int   checks = 0;
    obs_t expQ[$];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic stim_t mkS(logic rst, logic start, logic [9:0] addr, logic br, logic tk,
                                  logic [2:0] idx, logic rd, logic wr, logic rdy, logic halt);
        return '{rst, start, addr, br, tk, idx, rd, wr, rdy, halt};
    endfunction

    function automatic stim_t nop();
        return mkS(L0, L0, 10'd0, L0, L0, 3'd0, L0, L0, L0, L0);
    endfunction

    function automatic obs_t mkE(logic [9:0] pc, logic we, logic st, logic mr, logic dn,
                                 logic [15:0] cnt);
        return '{pc, we, st, mr, dn, cnt};
    endfunction

    function automatic obs_t sample();
        return '{ProgCtr, WriteEn, Stall, MemReq, Done, InstrCount};
    endfunction

    task automatic applyStim(input stim_t s);
        Reset     = s.rst;
        Start     = s.start;
        StartAddr = s.addr;
        Branch    = s.br;
        Taken     = s.tk;
        LutIdx    = s.idx;
        MemRead   = s.rd;
        MemWrite  = s.wr;
        MemReady  = s.rdy;
        HaltInstr = s.halt;
    endtask

    task automatic doStart(input logic [9:0] a);
        @(negedge Clk);
        applyStim(mkS(L0, L1, a, L0, L0, 3'd0, L0, L0, L0, L0));
    endtask

    task automatic test_reset();
        step_t q[$];
        obs_t  o, e;
        q.push_back('{mkS(L1, L1, 10'd9, L0, L0, 3'd0, L1, L0, L0, L0), mkE(10'd0, L0, L0, L0, L0, 16'd0)});
        q.push_back('{mkS(L1, L0, 10'd0, L0, L0, 3'd0, L0, L0, L0, L0), mkE(10'd0, L0, L0, L0, L0, 16'd0)});
        q.push_back('{nop(), mkE(10'd0, L0, L0, L0, L0, 16'd0)});
        foreach (q[i]) begin
            @(negedge Clk); applyStim(q[i].s); expQ.push_back(q[i].e);
            #1; o = sample(); e = expQ.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL reset[%0d] got=%p want=%p", i, o, e); end
        end
    endtask

    task automatic test_sequential();
        step_t q[$];
        obs_t  o, e;
        doStart(10'd5);
        for (int k = 0; k < 4; k++)
            q.push_back('{nop(), mkE(10'(5 + k), L1, L0, L0, L0, 16'(k))});
        q.push_back('{mkS(L0, L0, 10'd0, L1, L1, 3'd2, L0, L0, L0, L1), mkE(10'd9, L0, L0, L0, L0, 16'd4)});
        q.push_back('{nop(), mkE(10'd9, L0, L0, L0, L1, 16'd4)});
        foreach (q[i]) begin
            @(negedge Clk); applyStim(q[i].s); expQ.push_back(q[i].e);
            #1; o = sample(); e = expQ.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL sequential[%0d] got=%p want=%p", i, o, e); end
        end
    endtask

    task automatic test_branch();
        step_t q[$];
        obs_t  o, e;
        doStart(10'd12);
        q.push_back('{mkS(L0, L0, 10'd0, L1, L1, 3'd2, L0, L0, L0, L0), mkE(10'd12, L1, L0, L0, L0, 16'd0)});
        q.push_back('{nop(), mkE(10'd40, L1, L0, L0, L0, 16'd1)});
        q.push_back('{mkS(L0, L0, 10'd0, L1, L0, 3'd2, L0, L0, L0, L0), mkE(10'd41, L1, L0, L0, L0, 16'd2)});
        q.push_back('{mkS(L0, L0, 10'd0, L1, L1, 3'd7, L0, L0, L0, L0), mkE(10'd42, L1, L0, L0, L0, 16'd3)});
        q.push_back('{mkS(L0, L0, 10'd0, L0, L0, 3'd0, L0, L0, L0, L1), mkE(10'd1000, L0, L0, L0, L0, 16'd4)});
        q.push_back('{nop(), mkE(10'd1000, L0, L0, L0, L1, 16'd4)});
        foreach (q[i]) begin
            @(negedge Clk); applyStim(q[i].s); expQ.push_back(q[i].e);
            #1; o = sample(); e = expQ.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL branch[%0d] got=%p want=%p", i, o, e); end
        end
    endtask

    task automatic test_memwait();
        step_t q[$];
        obs_t  o, e;
        stim_t ldWait;
        ldWait = mkS(L0, L0, 10'd0, L0, L0, 3'd0, L1, L0, L0, L0);
        doStart(10'd20);
        for (int k = 0; k < 3; k++)
            q.push_back('{ldWait, mkE(10'd20, L0, L1, L1, L0, 16'd0)});
        q.push_back('{mkS(L0, L0, 10'd0, L0, L0, 3'd0, L1, L0, L1, L0), mkE(10'd20, L1, L0, L1, L0, 16'd0)});
        // Store with a taken branch: memory path wins, zero-wait retire.
        q.push_back('{mkS(L0, L0, 10'd0, L1, L1, 3'd2, L0, L1, L1, L0), mkE(10'd21, L1, L0, L1, L0, 16'd1)});
        q.push_back('{nop(), mkE(10'd22, L1, L0, L0, L0, 16'd2)});
        q.push_back('{mkS(L0, L0, 10'd0, L0, L0, 3'd0, L1, L0, L0, L1), mkE(10'd23, L0, L0, L0, L0, 16'd3)});
        q.push_back('{ldWait, mkE(10'd23, L0, L0, L0, L1, 16'd3)});
        foreach (q[i]) begin
            @(negedge Clk); applyStim(q[i].s); expQ.push_back(q[i].e);
            #1; o = sample(); e = expQ.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL memwait[%0d] got=%p want=%p", i, o, e); end
        end
    endtask

    task automatic test_halt_restart();
        step_t q[$];
        obs_t  o, e;
        doStart(10'd29);
        q.push_back('{nop(), mkE(10'd29, L1, L0, L0, L0, 16'd0)});
        q.push_back('{mkS(L0, L0, 10'd0, L1, L1, 3'd2, L0, L0, L0, L1), mkE(10'd30, L0, L0, L0, L0, 16'd1)});
        q.push_back('{nop(), mkE(10'd30, L0, L0, L0, L1, 16'd1)});
        q.push_back('{mkS(L0, L1, 10'd0, L0, L0, 3'd0, L0, L0, L0, L0), mkE(10'd30, L0, L0, L0, L1, 16'd1)});
        // Start while running must be ignored.
        q.push_back('{mkS(L0, L1, 10'd77, L0, L0, 3'd0, L0, L0, L0, L0), mkE(10'd0, L1, L0, L0, L0, 16'd0)});
        q.push_back('{mkS(L0, L0, 10'd0, L0, L0, 3'd0, L0, L0, L0, L1), mkE(10'd1, L0, L0, L0, L0, 16'd1)});
        q.push_back('{nop(), mkE(10'd1, L0, L0, L0, L1, 16'd1)});
        foreach (q[i]) begin
            @(negedge Clk); applyStim(q[i].s); expQ.push_back(q[i].e);
            #1; o = sample(); e = expQ.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL halt_restart[%0d] got=%p want=%p", i, o, e); end
        end
    endtask

    task automatic test_wrap();
        step_t q[$];
        obs_t  o, e;
        doStart(10'd1022);
        q.push_back('{nop(), mkE(10'd1022, L1, L0, L0, L0, 16'd0)});
        q.push_back('{nop(), mkE(10'd1023, L1, L0, L0, L0, 16'd1)});
        q.push_back('{nop(), mkE(10'd0,    L1, L0, L0, L0, 16'd2)});
        q.push_back('{mkS(L0, L0, 10'd0, L0, L0, 3'd0, L0, L0, L0, L1), mkE(10'd1, L0, L0, L0, L0, 16'd3)});
        q.push_back('{nop(), mkE(10'd1, L0, L0, L0, L1, 16'd3)});
        foreach (q[i]) begin
            @(negedge Clk); applyStim(q[i].s); expQ.push_back(q[i].e);
            #1; o = sample(); e = expQ.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL wrap[%0d] got=%p want=%p", i, o, e); end
        end
    endtask

    task automatic test_saturate();
        step_t q[$];
        obs_t  o, e;
        int    satExp;
        doStart(10'd100);
        for (int k = 0; k < 20; k++)
            q.push_back('{nop(), mkE(10'(100 + k), L1, L0, L0, L0, 16'(k))});
        q.push_back('{mkS(L0, L0, 10'd0, L0, L0, 3'd0, L0, L0, L0, L1), mkE(10'd120, L0, L0, L0, L0, 16'd20)});
        q.push_back('{nop(), mkE(10'd120, L0, L0, L0, L1, 16'd20)});
        foreach (q[i]) begin
            @(negedge Clk); applyStim(q[i].s); expQ.push_back(q[i].e);
            #1; o = sample(); e = expQ.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL saturate[%0d] got=%p want=%p", i, o, e); end
            satExp = (i > 20) ? 15 : ((i > 15) ? 15 : i);
            checks++;
            if (cntSat !== 4'(satExp)) begin
                errors++;
                $display("FAIL saturate_cnt4[%0d] got=%0d want=%0d", i, cntSat, satExp);
            end
        end
    endtask

    task automatic test_reset_memwait();
        step_t q[$];
        obs_t  o, e;
        doStart(10'd49);
        q.push_back('{nop(), mkE(10'd49, L1, L0, L0, L0, 16'd0)});
        q.push_back('{mkS(L0, L0, 10'd0, L0, L0, 3'd0, L1, L0, L0, L0), mkE(10'd50, L0, L1, L1, L0, 16'd1)});
        q.push_back('{mkS(L1, L0, 10'd0, L0, L0, 3'd0, L1, L0, L0, L0), mkE(10'd50, L0, L1, L1, L0, 16'd1)});
        // Late MemReady after reset must be ignored.
        q.push_back('{mkS(L0, L0, 10'd0, L0, L0, 3'd0, L1, L0, L1, L0), mkE(10'd0, L0, L0, L0, L0, 16'd0)});
        q.push_back('{mkS(L0, L0, 10'd0, L0, L0, 3'd0, L0, L0, L1, L0), mkE(10'd0, L0, L0, L0, L0, 16'd0)});
        foreach (q[i]) begin
            @(negedge Clk); applyStim(q[i].s); expQ.push_back(q[i].e);
            #1; o = sample(); e = expQ.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL reset_memwait[%0d] got=%p want=%p", i, o, e); end
        end
    endtask

    initial begin
        applyStim(mkS(L1, L0, 10'd0, L0, L0, 3'd0, L0, L0, L0, L0));
        test_reset();
        test_sequential();
        test_branch();
        test_memwait();
        test_halt_restart();
        test_wrap();
        test_saturate();
        test_reset_memwait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
